// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a valid/ready handshake and a one-entry skid
// buffer so in_ready never depends combinationally on out_ready. It also has a
// synchronous flush and a forwarding tap taken from the main entry.
module exe_mem_skid_reg #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEST_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] val_ra_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] val_ra,
    output logic [DATA_W-1:0] alu_res,
    output logic [DEST_W-1:0] dest,
    output logic [1:0]        occ,
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int unsigned PW = 3 + 2 * DATA_W + DEST_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   main_p, skid_p, in_p;
    logic            accept, drain;
    logic            load_main_skid, load_main_in, load_skid;

    assign in_p   = {wb_en_in, mem_r_en_in, mem_w_en_in, val_ra_in, alu_res_in, dest_in};
    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Next-state and entry-load decisions; flush outranks every transfer.
    always_comb begin
        state_next     = state;
        load_main_skid = 1'b0;
        load_main_in   = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else if (state == EMPTY || drain) begin
            if (state == FULL) begin
                load_main_skid = 1'b1;
                state_next     = ONE;
            end else if (accept) begin
                load_main_in = 1'b1;
                state_next   = ONE;
            end else begin
                state_next = EMPTY;
            end
        end else if (accept) begin
            load_skid  = 1'b1;
            state_next = FULL;
        end
    end

    // State register with registered handshake flags and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occ       <= 2'd0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next != EMPTY);
            in_ready  <= (state_next != FULL);
            case (state_next)
                EMPTY:   occ <= 2'd0;
                ONE:     occ <= 2'd1;
                FULL:    occ <= 2'd2;
                default: occ <= 2'd0;
            endcase
        end
    end

    // Payload storage for the main (output-facing) and skid entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_p <= '0;
            skid_p <= '0;
        end else begin
            if (load_main_skid) begin
                main_p <= skid_p;
            end else if (load_main_in) begin
                main_p <= in_p;
            end
            if (load_skid) begin
                skid_p <= in_p;
            end
        end
    end

    // Enables are gated by out_valid so bubbles never carry live controls.
    assign wb_en    = main_p[PW-1] & out_valid;
    assign mem_r_en = main_p[PW-2] & out_valid;
    assign mem_w_en = main_p[PW-3] & out_valid;
    assign val_ra   = main_p[2*DATA_W+DEST_W-1 -: DATA_W];
    assign alu_res  = main_p[DATA_W+DEST_W-1 -: DATA_W];
    assign dest     = main_p[DEST_W-1:0];

    assign fwd_valid = out_valid & wb_en & ~mem_r_en;
    assign fwd_dest  = dest;
    assign fwd_data  = alu_res;

endmodule

// File: doc/exe_mem_skid_reg.md
# exe_mem_skid_reg

Parametrised EXE→MEM pipeline register with a valid/ready handshake, a one-entry skid buffer, and synchronous flush. It carries the EXE-stage result bundle (write-back/memory enables, source-register value, ALU result, destination index) into the MEM stage. It lets MEM stall without a combinational ready path back through EXE. It also exports a forwarding tap for the hazard unit.

## Interface
- DATA_W, 8, width of val_ra and alu_res
- DEST_W, 2, width of destination register index
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  EXE bundle valid
- in_ready  out  1  block can accept this cycle (registered)
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control enables
- val_ra_in  in  DATA_W  source register A value
- alu_res_in  in  DATA_W  ALU result
- dest_in  in  DEST_W  destination register index
- out_valid  out  1  MEM bundle valid
- out_ready  in  1  MEM stage accepts this cycle
- wb_en, mem_r_en, mem_w_en  out  1 each  registered enables
- val_ra, alu_res  out  DATA_W  registered data
- dest  out  DEST_W  registered destination
- occ  out  2  entries held (0, 1, 2)
- fwd_valid  out  1  out_valid & wb_en & ~mem_r_en
- fwd_dest  out  DEST_W  equals dest
- fwd_data  out  DATA_W  equals alu_res

## Operation
- Payload P = {wb_en, mem_r_en, mem_w_en, val_ra, alu_res, dest}; width 3+2*DATA_W+DEST_W.
- Two entries: the main entry drives the outputs; the skid entry is internal.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = ~skid_valid. It is registered and never depends on out_ready in the same cycle.
- Next-state, with priority top-down:
  - rst: everything cleared asynchronously.
  - flush: main and skid invalidated. The input is ignored even if in_valid=1.
  - main empty or drain: the main entry loads from skid if skid_valid, else from the input if accept, else it becomes empty. Skid becomes empty.
  - main full and ~out_ready: if accept, the input goes into skid. Main holds.
- The states are EMPTY (occ 0), ONE (occ 1, main only) and FULL (occ 2, main+skid):
  - EMPTY→ONE on accept.
  - ONE→EMPTY on drain without accept.
  - ONE→FULL on accept without drain.
  - ONE stays ONE on accept with drain, or on idle.
  - FULL→ONE on drain. No accept is possible in FULL.
  - Any state→EMPTY on flush.
- Bubble rule: whenever out_valid=0, wb_en, mem_r_en and mem_w_en read 0. val_ra, alu_res and dest may hold stale data.
- Order is preserved strictly (FIFO). No bundle is duplicated or dropped except by flush.
- The forwarding tap is combinational from the main entry only. The skid entry is never forwarded.

## Timing
- Reset values: all outputs 0 except in_ready=1. occ=0.
- Latency is 1 cycle, from accept at edge N to out_valid at N+1 (when entering EMPTY or a draining ONE).
- Throughput is 1 bundle/cycle with out_ready held high.
- After out_ready falls with main full, one more bundle is absorbed into skid. in_ready drops the following cycle.
- in_ready rises the cycle after the drain that empties skid.
- Flush takes effect at the clock edge. It has no effect on outputs until that edge. in_ready=1 after the edge.
- Flush and drain in the same cycle: the drain completes downstream and both entries are cleared.
- Reset mid-transfer: outputs clear immediately without waiting for clk. The bundle in flight is lost.

## Test plan
- Streaming: out_ready=1, feed alu_res 0x01..0x08 back-to-back → out_valid for 8 consecutive cycles, values in order, 1-cycle latency, occ ≤1.
- Stall/skid: send 0x10,0x11,0x12 with out_ready=0 from cycle 1 → 0x10 held on outputs, 0x11 in skid, occ=2, in_ready=0. 0x12 is not accepted until out_ready=1, then 0x10,0x11,0x12 appear in order.
- Flush in FULL: occ=2, assert flush with in_valid=1 (0x33) → next cycle out_valid=0, wb_en=mem_r_en=mem_w_en=0, occ=0, in_ready=1, and 0x33 never appears.
- Forwarding: bundle wb_en=1, mem_r_en=0, dest=2, alu_res=0x5A → fwd_valid=1, fwd_dest=2, fwd_data=0x5A. Same bundle with mem_r_en=1 → fwd_valid=0.
- Async reset: assert rst mid-cycle while occ=2 → outputs 0, in_ready=1 before the next clk edge. After release, the first accepted bundle appears 1 cycle later.
- Parameters: DATA_W=16, DEST_W=4, val_ra_in=0xBEEF, dest_in=0xF → outputs carry 0xBEEF and 0xF unchanged.
